// File: rtl/sample_sequencer.sv
// Periodic sample sequencer: tick -> SPI read -> calculation -> rounded/clamped actuator command.
// Define SEQ_TIMEOUT_EN to build the watchdog that ends a stalled wait with a zero command.
module sample_sequencer #(
    parameter int unsigned CYCLES_PER_SAMPLE = 30000,
    parameter int unsigned CNT_WIDTH         = 15,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned OUT_WIDTH         = 15,
    parameter int unsigned SHIFT             = 16,
    parameter int unsigned SAT_LIMIT         = 999,
    parameter int unsigned TIMEOUT_CYCLES    = 20000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         clear_flags,
    output logic                         spi_start,
    input  logic                         spi_done,
    output logic                         calc_start,
    input  logic                         calc_done,
    input  logic signed [DATA_WIDTH-1:0] calc_result,
    output logic signed [OUT_WIDTH-1:0]  actuator_cmd,
    output logic                         cmd_valid,
    output logic                         sat,
    output logic                         busy,
    output logic                         overrun,
    output logic [7:0]                   overrun_cnt,
    output logic                         timeout
);

    if (SHIFT == 0 || TIMEOUT_CYCLES == 0 || CYCLES_PER_SAMPLE == 0 ||
        64'(CYCLES_PER_SAMPLE) > (64'd1 << CNT_WIDTH)) begin : g_bad_params
        $error("sample_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StSpiWait, StCalcWait, StUpdate} state_e;

    localparam logic [CNT_WIDTH-1:0]       CntMax = CNT_WIDTH'(CYCLES_PER_SAMPLE - 1);
    localparam logic signed [DATA_WIDTH:0] Half   = {{DATA_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [DATA_WIDTH:0] SatPos = (DATA_WIDTH + 1)'(SAT_LIMIT);
    localparam logic signed [DATA_WIDTH:0] SatNeg = -SatPos;

    state_e state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic tick;
    logic spi_done_q, calc_done_q;
    logic spi_rise, calc_rise;
    logic enter_spi, enter_calc, enter_update, wd_fire, wd_hit;
    logic overrun_set;

    logic signed [DATA_WIDTH:0]  ext, rounded, shifted;
    logic signed [OUT_WIDTH-1:0] cmd_next;
    logic                        clamp_hit;

    // Sample period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!enable || cnt_q == CntMax) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign tick = enable && (cnt_q == CntMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_done_q  <= 1'b0;
            calc_done_q <= 1'b0;
        end else begin
            spi_done_q  <= spi_done;
            calc_done_q <= calc_done;
        end
    end

    assign spi_rise  = spi_done && !spi_done_q;
    assign calc_rise = calc_done && !calc_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        enter_spi    = 1'b0;
        enter_calc   = 1'b0;
        enter_update = 1'b0;
        wd_fire      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d   = StSpiWait;
                    enter_spi = 1'b1;
                end
            end
            StSpiWait: begin
                if (spi_rise) begin
                    state_d    = StCalcWait;
                    enter_calc = 1'b1;
                end else if (wd_hit) begin
                    state_d = StIdle;
                    wd_fire = 1'b1;
                end
            end
            StCalcWait: begin
                if (calc_rise) begin
                    state_d      = StUpdate;
                    enter_update = 1'b1;
                end else if (wd_hit) begin
                    state_d = StIdle;
                    wd_fire = 1'b1;
                end
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign overrun_set = tick && (state_q != StIdle);

    // Round half up, arithmetic shift, then symmetric clamp; DATA_WIDTH+1 bits cannot overflow
    always_comb begin
        ext       = {calc_result[DATA_WIDTH-1], calc_result};
        rounded   = ext + Half;
        shifted   = rounded >>> SHIFT;
        cmd_next  = shifted[OUT_WIDTH-1:0];
        clamp_hit = 1'b0;
        if (shifted > SatPos) begin
            cmd_next  = SatPos[OUT_WIDTH-1:0];
            clamp_hit = 1'b1;
        end else if (shifted < SatNeg) begin
            cmd_next  = SatNeg[OUT_WIDTH-1:0];
            clamp_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_start    <= 1'b0;
            calc_start   <= 1'b0;
            cmd_valid    <= 1'b0;
            actuator_cmd <= '0;
            sat          <= 1'b0;
        end else begin
            spi_start  <= enter_spi;
            calc_start <= enter_calc;
            cmd_valid  <= enter_update | wd_fire;
            if (enter_update) begin
                actuator_cmd <= cmd_next;
                sat          <= clamp_hit;
            end else if (wd_fire) begin
                actuator_cmd <= '0;
                sat          <= 1'b0;
            end else if (!enable && state_q == StIdle) begin
                actuator_cmd <= '0;
            end
        end
    end

    // A set in the same cycle as clear_flags wins and restarts the count at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
            if (clear_flags) begin
                overrun_cnt <= 8'd1;
            end else if (overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end else if (clear_flags) begin
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned         WdWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdWidth-1:0]  WdMax   = WdWidth'(TIMEOUT_CYCLES - 1);

    logic [WdWidth-1:0] wd_q;
    logic               waiting;

    assign waiting = (state_q == StSpiWait) || (state_q == StCalcWait);
    assign wd_hit  = waiting && (wd_q == WdMax);

    // Restarts on entry to each wait state, so each wait gets its own budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (enter_spi || enter_calc || !waiting) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WdWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (wd_fire) begin
            timeout <= 1'b1;
        end else if (clear_flags) begin
            timeout <= 1'b0;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: directed literal checks plus randomized traffic against a
// cycle-level behavioural model of the sampling/sequencing rules.
module tb_sample_sequencer;

    localparam int Cps     = 100;
    localparam int CntW    = 7;
    localparam int DataW   = 32;
    localparam int OutW    = 15;
    localparam int Shift   = 16;
    localparam int SatLim  = 999;
    localparam int ToCyc   = 50;

    localparam int PhIdle = 0;
    localparam int PhSpi  = 1;
    localparam int PhCalc = 2;
    localparam int PhUpd  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic clear_flags = 1'b0;
    logic spi_done = 1'b0;
    logic calc_done = 1'b0;
    logic signed [DataW-1:0] calc_result = '0;

    logic spi_start, calc_start, cmd_valid, sat, busy, overrun, timeout;
    logic signed [OutW-1:0] actuator_cmd;
    logic [7:0] overrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_cnt, m_phase, m_wait, m_cmd, m_ovc;
    bit m_psd, m_pcd, m_spi, m_calc, m_valid, m_sat, m_ov, m_to;

    always #5 clk = ~clk;

    sample_sequencer #(
        .CYCLES_PER_SAMPLE(Cps),
        .CNT_WIDTH        (CntW),
        .DATA_WIDTH       (DataW),
        .OUT_WIDTH        (OutW),
        .SHIFT            (Shift),
        .SAT_LIMIT        (SatLim),
        .TIMEOUT_CYCLES   (ToCyc)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear_flags (clear_flags),
        .spi_start   (spi_start),
        .spi_done    (spi_done),
        .calc_start  (calc_start),
        .calc_done   (calc_done),
        .calc_result (calc_result),
        .actuator_cmd(actuator_cmd),
        .cmd_valid   (cmd_valid),
        .sat         (sat),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .timeout     (timeout)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // floor((x + 2^(Shift-1)) / 2^Shift), then clamp to +/-SatLim
    function automatic int scale_cmd(input longint x, output bit clipped);
        longint num, den, q;
        num = x + (longint'(1) << (Shift - 1));
        den = longint'(1) << Shift;
        q = num / den;
        if (num < 0 && q * den != num) q = q - 1;
        clipped = 1'b0;
        if (q > SatLim) begin
            q = SatLim;
            clipped = 1'b1;
        end else if (q < -SatLim) begin
            q = -SatLim;
            clipped = 1'b1;
        end
        return int'(q);
    endfunction

    function automatic bit wait_expired();
`ifdef SEQ_TIMEOUT_EN
        return (m_wait + 1 >= ToCyc);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_phase = PhIdle; m_wait = 0; m_cmd = 0; m_ovc = 0;
        m_psd = 0; m_pcd = 0; m_spi = 0; m_calc = 0; m_valid = 0;
        m_sat = 0; m_ov = 0; m_to = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit tick, sr, cr, ov_set, to_set, clipped;
        tick   = enable && (m_cnt == Cps - 1);
        sr     = spi_done && !m_psd;
        cr     = calc_done && !m_pcd;
        ov_set = tick && (m_phase != PhIdle);
        to_set = 1'b0;
        m_spi = 0; m_calc = 0; m_valid = 0;
        case (m_phase)
            PhIdle: begin
                if (tick) begin
                    m_phase = PhSpi; m_spi = 1; m_wait = 0;
                end else if (!enable) begin
                    m_cmd = 0;
                end
            end
            PhSpi: begin
                if (sr) begin
                    m_phase = PhCalc; m_calc = 1; m_wait = 0;
                end else if (wait_expired()) begin
                    to_set = 1;
                end else begin
                    m_wait++;
                end
            end
            PhCalc: begin
                if (cr) begin
                    m_phase = PhUpd; m_valid = 1;
                    m_cmd = scale_cmd(longint'(calc_result), clipped);
                    m_sat = clipped;
                end else if (wait_expired()) begin
                    to_set = 1;
                end else begin
                    m_wait++;
                end
            end
            default: m_phase = PhIdle;
        endcase
        if (to_set) begin
            m_phase = PhIdle; m_cmd = 0; m_sat = 0; m_valid = 1;
        end
        if (clear_flags) begin
            m_ov = 0; m_ovc = 0; m_to = 0;
        end
        if (ov_set) begin
            m_ov = 1;
            if (m_ovc < 255) m_ovc++;
        end
        if (to_set) m_to = 1;
        m_cnt = enable ? (m_cnt + 1) % Cps : 0;
        m_psd = spi_done;
        m_pcd = calc_done;
    endtask

    task automatic compare_all();
        chk("spi_start", spi_start, m_spi);
        chk("calc_start", calc_start, m_calc);
        chk("cmd_valid", cmd_valid, m_valid);
        chk("actuator_cmd", longint'(actuator_cmd), m_cmd);
        chk("sat", sat, m_sat);
        chk("busy", busy, m_phase != PhIdle);
        chk("overrun", overrun, m_ov);
        chk("overrun_cnt", overrun_cnt, m_ovc);
        chk("timeout", timeout, m_to);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_spi_start", spi_start, 0);
        chk("rst_calc_start", calc_start, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_actuator_cmd", longint'(actuator_cmd), 0);
        chk("rst_sat", sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_overrun_cnt", overrun_cnt, 0);
        chk("rst_timeout", timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // sel: 0 spi_start, 1 calc_start, 2 cmd_valid
    task automatic wait_sig(input int sel, input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            step();
            n++;
            seen = (sel == 0) ? spi_start : (sel == 1) ? calc_start : cmd_valid;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL wait_pulse_%0d: no pulse within %0d cycles", sel, budget);
        end
    endtask

    task automatic finish_seq(input logic [31:0] val);
        int n;
        spi_done = 1'b1;
        wait_sig(1, 5, n);
        spi_done = 1'b0;
        calc_result = val;
        calc_done = 1'b1;
        wait_sig(2, 5, n);
        calc_done = 1'b0;
    endtask

    task automatic run_sample(input logic [31:0] val, input string name,
                              input int exp_cmd, input bit exp_sat);
        int n;
        wait_sig(0, 200, n);
        finish_seq(val);
        chk({name, "_cmd"}, longint'($unsigned(actuator_cmd)), exp_cmd);
        chk({name, "_sat"}, sat, exp_sat);
    endtask

    logic [31:0] corner [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h00018000,
                                32'h00017FFF, 32'hFFFF7FFF, 32'h03E78000};

    initial begin
        int n, nsp, nidle, rate;
        do_reset();
        enable = 1'b1;

        wait_sig(0, 200, n);
        chk("first_spi_start_latency", n, 100);
        finish_seq(32'h0);

        run_sample(32'h00018000, "round_up", 2, 1'b0);
        run_sample(32'h00017FFF, "round_down", 1, 1'b0);
        run_sample(32'hFFFF7FFF, "round_neg", 15'h7FFF, 1'b0);
        run_sample(32'h7FFFFFFF, "clamp_pos", 999, 1'b1);
        run_sample(32'h80000000, "clamp_neg", 15'h7C19, 1'b1);

        // spi_done never rises
        wait_sig(0, 200, n);
`ifdef SEQ_TIMEOUT_EN
        repeat (ToCyc - 1) step();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("wd_timeout", timeout, 1);
        chk("wd_cmd_valid", cmd_valid, 1);
        chk("wd_actuator_cmd", longint'(actuator_cmd), 0);
        chk("wd_sat", sat, 0);
        chk("wd_busy", busy, 0);
`else
        nsp = 0;
        nidle = 0;
        for (int i = 1; i <= 150; i++) begin
            step();
            if (spi_start) nsp++;
            if (!busy) nidle++;
            if (i == 100) begin
                chk("ovr_overrun", overrun, 1);
                chk("ovr_overrun_cnt", overrun_cnt, 1);
            end
        end
        chk("ovr_extra_spi_start", nsp, 0);
        chk("stall_busy_dropped", nidle, 0);
        finish_seq(32'h7FFFFFFF);

        // clear_flags coincides with the next overrun tick
        wait_sig(0, 200, n);
        repeat (Cps - 1) step();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("prio_overrun", overrun, 1);
        chk("prio_overrun_cnt", overrun_cnt, 1);
        finish_seq(32'h7FFFFFFF);
`endif

        // reset in the middle of CALC_WAIT
        wait_sig(0, 200, n);
        spi_done = 1'b1;
        wait_sig(1, 5, n);
        spi_done = 1'b0;
        step();
        step();
        chk("pre_reset_busy", busy, 1);
        do_reset();
        wait_sig(0, 200, n);
        chk("post_reset_spi_start", n, 100);

        rate = 8;
        for (int c = 0; c < 20000; c++) begin
            if (c % 1000 == 0) begin
                case ($urandom_range(0, 3))
                    0: rate = 2;
                    1: rate = 8;
                    2: rate = 64;
                    default: rate = 400;
                endcase
            end
            if ($urandom_range(0, rate - 1) == 0) spi_done = ~spi_done;
            if ($urandom_range(0, rate - 1) == 0) calc_done = ~calc_done;
            if ($urandom_range(0, 3) == 0) calc_result = corner[$urandom_range(0, 5)];
            else calc_result = $urandom;
            clear_flags = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 699) == 0) enable = ~enable;
            if ($urandom_range(0, 2999) == 0) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 SHALL provide parameter CYCLES_PER_SAMPLE, default 30000: sampling period in clk cycles.
REQ-002 SHALL provide parameter CNT_WIDTH, default 15: width of the sample counter; must hold CYCLES_PER_SAMPLE-1.
REQ-003 SHALL provide parameter DATA_WIDTH, default 32: width of the signed calc_result.
REQ-004 SHALL provide parameter OUT_WIDTH, default 15: width of the signed actuator_cmd.
REQ-005 SHALL provide parameter SHIFT, default 16: right-shift applied to the rounded result; SHIFT >= 1.
REQ-006 SHALL provide parameter SAT_LIMIT, default 999: symmetric clamp magnitude.
REQ-007 SHALL provide parameter TIMEOUT_CYCLES, default 20000: watchdog limit.
REQ-008 SHALL have ports clk (in, 1, the only clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-009 SHALL have ports enable (in, 1, run sampling) and clear_flags (in, 1, clears sticky flags).
REQ-010 SHALL have ports spi_start (out, 1, one-cycle pulse) and spi_done (in, 1, level; completion is its rising edge).
REQ-011 SHALL have ports calc_start (out, 1, one-cycle pulse), calc_done (in, 1, level; completion is its rising edge) and calc_result (in, DATA_WIDTH, signed).
REQ-012 SHALL have ports actuator_cmd (out, OUT_WIDTH, signed), cmd_valid (out, 1, one-cycle pulse) and sat (out, 1, last command was clamped).
REQ-013 SHALL have ports busy (out, 1), overrun (out, 1, sticky), overrun_cnt (out, 8) and timeout (out, 1, sticky).

Function
REQ-014 SHALL count 0..CYCLES_PER_SAMPLE-1 and wrap while enable=1; a tick is the cycle in which the count equals CYCLES_PER_SAMPLE-1.
REQ-015 SHALL hold the counter at 0 and generate no ticks while enable=0.
REQ-016 SHALL implement FSM IDLE -> SPI_WAIT -> CALC_WAIT -> UPDATE -> IDLE; busy=1 in every state except IDLE.
REQ-017 SHALL, on a tick in IDLE, enter SPI_WAIT and assert spi_start for exactly the first SPI_WAIT cycle.
REQ-018 SHALL detect edges against a registered copy of each done input that updates every cycle; a level already high on state entry SHALL NOT count as completion.
REQ-019 SHALL, on a spi_done rising edge in SPI_WAIT, enter CALC_WAIT and pulse calc_start on the first CALC_WAIT cycle.
REQ-020 SHALL, on a calc_done rising edge in CALC_WAIT, capture calc_result, enter UPDATE, register actuator_cmd and sat, and pulse cmd_valid, then return to IDLE.
REQ-021 SHALL compute the output as: rounded = calc_result + 2^(SHIFT-1) in DATA_WIDTH+1 bits; arithmetic right shift by SHIFT; clamp to [-SAT_LIMIT, +SAT_LIMIT]; truncate to OUT_WIDTH bits.
REQ-022 SHALL set sat=1 exactly when the clamp changed the value.
REQ-023 SHALL, on a tick outside IDLE, drop the tick, set overrun and increment overrun_cnt, saturating at 255.
REQ-024 SHALL clear overrun, overrun_cnt and timeout on clear_flags=1; if a set condition occurs in the same cycle, the set wins and the count becomes 1.
REQ-025 SHALL ignore done edges that arrive in any state other than the waiting state for that input.
REQ-026 SHALL, while enable=0 and the FSM is in IDLE, drive actuator_cmd to 0 from the next cycle; a sequence already in flight completes normally.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-sequence, immediately force: FSM to IDLE, counter to 0, edge registers to 0, and every output to 0 (spi_start, calc_start, cmd_valid, actuator_cmd, sat, busy, overrun, overrun_cnt, timeout).
REQ-028 SHALL begin counting on the first clk edge after rst_n deasserts, if enable=1.

Configuration
REQ-029 SHALL include the watchdog only when macro SEQ_TIMEOUT_EN is defined.
REQ-030 SHALL, with SEQ_TIMEOUT_EN defined, end a sequence that has spent TIMEOUT_CYCLES cycles in SPI_WAIT or CALC_WAIT: return to IDLE, set timeout, force actuator_cmd=0 and sat=0, and pulse cmd_valid.
REQ-031 SHALL, without SEQ_TIMEOUT_EN, wait indefinitely for done edges and tie timeout to 0.

Verification (CYCLES_PER_SAMPLE=100, SHIFT=16, OUT_WIDTH=15, SAT_LIMIT=999, TIMEOUT_CYCLES=50)
REQ-032 SHALL test rounding: calc_result 0x00018000 -> actuator_cmd 2; 0x00017FFF -> 1; 0xFFFF7FFF -> -1 (15'h7FFF); sat=0 in each case.
REQ-033 SHALL test clamping: 0x7FFFFFFF -> 999 with sat=1; 0x80000000 -> 15'h7C19 (-999) with sat=1.
REQ-034 SHALL test overrun: spi_done held low for 150 cycles -> overrun=1 and overrun_cnt=1 at the tick, and no second spi_start.
REQ-035 SHALL test reset: rst_n pulsed low during CALC_WAIT -> all outputs 0 and busy=0 immediately; spi_start pulses again 100 cycles after release.
REQ-036 SHALL test the watchdog: spi_done never rises -> with SEQ_TIMEOUT_EN, timeout=1, cmd_valid pulse and actuator_cmd=0 after 50 SPI_WAIT cycles; without it, busy stays 1.
REQ-037 SHALL test flag priority: clear_flags=1 in the same cycle as an overrun tick -> overrun=1 and overrun_cnt=1.
